// File: rtl/video_rgb_to_raw.sv
`default_nettype none
// ============================================================================
//  Module      : video_rgb_to_raw
//  Description : Converts an AXI4-Stream RGB pixel stream into a Bayer RAW
//                stream with a Wishbone-programmable phase. Defining
//                VIDEO_RGB_TO_RAW_FRAME_COUNT_EN adds a FRAME_COUNT register.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_rgb_to_raw #(
    parameter int         WB_ADR_WIDTH     = 8,
    parameter int         WB_DAT_WIDTH     = 32,
    parameter int         WB_SEL_WIDTH     = WB_DAT_WIDTH / 8,
    parameter int         DATA_WIDTH       = 10,
    parameter int         TUSER_WIDTH      = 1,
    parameter logic [1:0] INIT_PARAM_PHASE = 2'b11
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      in_update_req,

    input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
    input  logic                      s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]   s_wb_sel_i,
    input  logic                      s_wb_stb_i,
    output logic                      s_wb_ack_o,

    input  logic [TUSER_WIDTH-1:0]    s_axi4s_tuser,
    input  logic                      s_axi4s_tlast,
    input  logic [4*DATA_WIDTH-1:0]   s_axi4s_tdata,
    input  logic                      s_axi4s_tvalid,
    output logic                      s_axi4s_tready,

    output logic [TUSER_WIDTH-1:0]    m_axi4s_tuser,
    output logic                      m_axi4s_tlast,
    output logic [DATA_WIDTH-1:0]     m_axi4s_tdata,
    output logic                      m_axi4s_tvalid,
    input  logic                      m_axi4s_tready
);

    localparam logic [31:0]             CORE_ID           = 32'h527A_2130;
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_ID       = WB_ADR_WIDTH'(0);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL_UPDATE    = WB_ADR_WIDTH'(1);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_PARAM_PHASE   = WB_ADR_WIDTH'(2);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CURRENT_PHASE = WB_ADR_WIDTH'(3);
`ifdef VIDEO_RGB_TO_RAW_FRAME_COUNT_EN
    localparam logic [WB_ADR_WIDTH-1:0] ADR_FRAME_COUNT   = WB_ADR_WIDTH'(4);
`endif

    logic                  beat_accept;
    logic                  frame_start;
    logic                  wb_write;
    logic                  update_set;
    logic                  update_clr;
    logic                  pending;
    logic [1:0]            param_phase;
    logic [1:0]            active_phase;
    logic [1:0]            use_phase;
    logic                  x;
    logic                  y;
    logic                  x_cur;
    logic                  y_cur;
    logic                  px;
    logic                  py;
    logic [DATA_WIDTH-1:0] comp_r;
    logic [DATA_WIDTH-1:0] comp_g;
    logic [DATA_WIDTH-1:0] comp_b;
    logic [DATA_WIDTH-1:0] pixel;
    logic                  unused_inputs;

    assign unused_inputs = ^{s_wb_sel_i, s_wb_dat_i,
                             s_axi4s_tdata[4*DATA_WIDTH-1:3*DATA_WIDTH], s_axi4s_tuser};

    assign comp_r = s_axi4s_tdata[3*DATA_WIDTH-1:2*DATA_WIDTH];
    assign comp_g = s_axi4s_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign comp_b = s_axi4s_tdata[DATA_WIDTH-1:0];

    assign s_axi4s_tready = !m_axi4s_tvalid || m_axi4s_tready;
    assign beat_accept    = s_axi4s_tvalid && s_axi4s_tready;
    assign frame_start    = s_axi4s_tuser[0];

    // A frame-start beat is always (0,0); a pending update applies to that very beat.
    assign x_cur      = frame_start ? 1'b0 : x;
    assign y_cur      = frame_start ? 1'b0 : y;
    assign update_clr = beat_accept && frame_start && pending;
    assign use_phase  = (frame_start && pending) ? param_phase : active_phase;
    assign px         = x_cur ^ use_phase[0];
    assign py         = y_cur ^ use_phase[1];

    always_comb begin
        pixel = comp_g;
        if (!px && !py) begin
            pixel = comp_r;
        end else if (px && py) begin
            pixel = comp_b;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x <= 1'b0;
            y <= 1'b0;
        end else if (beat_accept) begin
            if (s_axi4s_tlast) begin
                x <= 1'b0;
                y <= ~y_cur;
            end else begin
                x <= ~x_cur;
                y <= y_cur;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axi4s_tvalid <= 1'b0;
            m_axi4s_tdata  <= '0;
            m_axi4s_tuser  <= '0;
            m_axi4s_tlast  <= 1'b0;
        end else if (s_axi4s_tready) begin
            m_axi4s_tvalid <= s_axi4s_tvalid;
            if (s_axi4s_tvalid) begin
                m_axi4s_tdata <= pixel;
                m_axi4s_tuser <= s_axi4s_tuser;
                m_axi4s_tlast <= s_axi4s_tlast;
            end
        end
    end

    assign s_wb_ack_o = s_wb_stb_i;
    assign wb_write   = s_wb_stb_i && s_wb_we_i;
    assign update_set = in_update_req ||
                        (wb_write && (s_wb_adr_i == ADR_CTL_UPDATE) && s_wb_sel_i[0] && s_wb_dat_i[0]);

    // Set has priority so a request landing on the consuming frame start is kept.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pending <= 1'b0;
        end else if (update_set) begin
            pending <= 1'b1;
        end else if (update_clr) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            param_phase  <= INIT_PARAM_PHASE;
            active_phase <= INIT_PARAM_PHASE;
        end else begin
            if (wb_write && (s_wb_adr_i == ADR_PARAM_PHASE) && s_wb_sel_i[0]) begin
                param_phase <= s_wb_dat_i[1:0];
            end
            if (update_clr) begin
                active_phase <= param_phase;
            end
        end
    end

`ifdef VIDEO_RGB_TO_RAW_FRAME_COUNT_EN
    logic [31:0] frame_count;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_count <= 32'd0;
        end else if (beat_accept && frame_start) begin
            frame_count <= frame_count + 32'd1;
        end
    end
`endif

    always_comb begin
        s_wb_dat_o = '0;
        case (s_wb_adr_i)
            ADR_CORE_ID:       s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
            ADR_CTL_UPDATE:    s_wb_dat_o = WB_DAT_WIDTH'(pending);
            ADR_PARAM_PHASE:   s_wb_dat_o = WB_DAT_WIDTH'(param_phase);
            ADR_CURRENT_PHASE: s_wb_dat_o = WB_DAT_WIDTH'(active_phase);
`ifdef VIDEO_RGB_TO_RAW_FRAME_COUNT_EN
            ADR_FRAME_COUNT:   s_wb_dat_o = WB_DAT_WIDTH'(frame_count);
`endif
            default:           s_wb_dat_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_video_rgb_to_raw.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_rgb_to_raw
//  Description : Randomised self-checking bench for video_rgb_to_raw with a
//                frame-position Bayer reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_rgb_to_raw;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        in_update_req = 1'b0;
    logic [7:0]  s_wb_adr_i = '0;
    logic [31:0] s_wb_dat_i = '0;
    logic [31:0] s_wb_dat_o;
    logic        s_wb_we_i = 1'b0;
    logic [3:0]  s_wb_sel_i = '0;
    logic        s_wb_stb_i = 1'b0;
    logic        s_wb_ack_o;
    logic [0:0]  s_axi4s_tuser = '0;
    logic        s_axi4s_tlast = 1'b0;
    logic [39:0] s_axi4s_tdata = '0;
    logic        s_axi4s_tvalid = 1'b0;
    logic        s_axi4s_tready;
    logic [0:0]  m_axi4s_tuser;
    logic        m_axi4s_tlast;
    logic [9:0]  m_axi4s_tdata;
    logic        m_axi4s_tvalid;
    logic        m_axi4s_tready = 1'b1;

    video_rgb_to_raw dut (
        .aclk(aclk), .aresetn(aresetn), .in_update_req(in_update_req),
        .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_dat_o(s_wb_dat_o),
        .s_wb_we_i(s_wb_we_i), .s_wb_sel_i(s_wb_sel_i), .s_wb_stb_i(s_wb_stb_i),
        .s_wb_ack_o(s_wb_ack_o),
        .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
        .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_tvalid(s_axi4s_tvalid),
        .s_axi4s_tready(s_axi4s_tready),
        .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
        .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
        .m_axi4s_tready(m_axi4s_tready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed { logic fs; logic last; logic [39:0] data; } beat_t;
    typedef struct packed { logic fs; logic last; logic [9:0] data; } out_t;

    beat_t      in_q[$];
    out_t       exp_q[$];
    logic [9:0] recv_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    // Reference model: frame position as plain row/column counts.
    int         mcol, mrow, mframes;
    logic [1:0] mphase, mparam;
    bit         mpend;

    function automatic void model_reset();
        mcol = 0; mrow = 0; mframes = 0;
        mphase = 2'b11; mparam = 2'b11; mpend = 1'b0;
    endfunction

    function automatic void push_beat(input bit fs, input bit last,
                                      input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        beat_t bt; out_t ot; int px, py;
        if (fs) begin
            mcol = 0; mrow = 0; mframes++;
            if (mpend) begin mphase = mparam; mpend = 1'b0; end
        end
        px = (mcol % 2) ^ int'(mphase[0]);
        py = (mrow % 2) ^ int'(mphase[1]);
        bt.fs = fs; bt.last = last; bt.data = {10'($urandom), r, g, b};
        ot.fs = fs; ot.last = last;
        if (px == 0 && py == 0)      ot.data = r;
        else if (px == 1 && py == 1) ot.data = b;
        else                         ot.data = g;
        in_q.push_back(bt);
        exp_q.push_back(ot);
        if (last) begin mcol = 0; mrow++; end
        else mcol++;
    endfunction

    function automatic void push_frame(input int w, input int h, input bit with_fs, input bit rnd,
                                       input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                if (rnd) push_beat(with_fs && xx == 0 && yy == 0, xx == w - 1,
                                   10'($urandom), 10'($urandom), 10'($urandom));
                else     push_beat(with_fs && xx == 0 && yy == 0, xx == w - 1, r, g, b);
    endfunction

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] sel);
        @(negedge aclk);
        s_wb_adr_i = a; s_wb_dat_i = d; s_wb_sel_i = sel; s_wb_we_i = 1'b1; s_wb_stb_i = 1'b1;
        @(posedge aclk);
        #1 s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge aclk);
        s_wb_adr_i = a; s_wb_we_i = 1'b0; s_wb_sel_i = 4'hF; s_wb_stb_i = 1'b1;
        #1 d = s_wb_dat_o;
        vectors++;
        if (s_wb_ack_o !== 1'b1) begin
            miscompares++;
            $display("FAIL wb_ack adr=%0h: got %b, required 1", a, s_wb_ack_o);
        end
        @(posedge aclk);
        #1 s_wb_stb_i = 1'b0;
    endtask

    task automatic run_stream(input int rdy_pct, input int vld_pct);
        int n, got, budget;
        n = exp_q.size(); got = 0; budget = 40 * n + 200;
        recv_q.delete();
        fork
            begin : drv
                int cyc; bit pres; beat_t b;
                cyc = 0; pres = 1'b0;
                while (in_q.size() > 0 && cyc < budget) begin
                    @(negedge aclk); cyc++;
                    if (pres || $urandom_range(99) < vld_pct) begin
                        b = in_q[0];
                        s_axi4s_tvalid = 1'b1; s_axi4s_tuser = b.fs;
                        s_axi4s_tlast = b.last; s_axi4s_tdata = b.data; pres = 1'b1;
                        #1;
                        if (s_axi4s_tready) begin void'(in_q.pop_front()); pres = 1'b0; end
                    end else begin
                        s_axi4s_tvalid = 1'b0;
                    end
                end
                vectors++;
                if (in_q.size() > 0) begin
                    miscompares++;
                    $display("FAIL drive_timeout: %0d beats left, required 0", in_q.size());
                    in_q.delete();
                end
                @(negedge aclk);
                s_axi4s_tvalid = 1'b0; s_axi4s_tuser = '0; s_axi4s_tlast = 1'b0;
            end
            begin : mon
                int cyc; bit stalled; logic [9:0] held; out_t e;
                cyc = 0; stalled = 1'b0; held = '0;
                while (got < n && cyc < budget) begin
                    @(negedge aclk); cyc++;
                    m_axi4s_tready = ($urandom_range(99) < rdy_pct);
                    #1;
                    if (stalled) begin
                        vectors++;
                        if (m_axi4s_tvalid !== 1'b1 || m_axi4s_tdata !== held) begin
                            miscompares++;
                            $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                                     m_axi4s_tvalid, m_axi4s_tdata, held);
                        end
                    end
                    stalled = 1'b0;
                    if (m_axi4s_tvalid === 1'b1) begin
                        if (m_axi4s_tready) begin
                            e = exp_q.pop_front();
                            vectors++;
                            if (m_axi4s_tdata !== e.data || m_axi4s_tuser !== e.fs || m_axi4s_tlast !== e.last) begin
                                miscompares++;
                                $display("FAIL beat%0d: got data=%h user=%b last=%b, required data=%h user=%b last=%b",
                                         got, m_axi4s_tdata, m_axi4s_tuser, m_axi4s_tlast, e.data, e.fs, e.last);
                            end
                            recv_q.push_back(m_axi4s_tdata);
                            got++;
                        end else begin
                            stalled = 1'b1; held = m_axi4s_tdata;
                        end
                    end
                end
                vectors++;
                if (got < n) begin
                    miscompares++;
                    $display("FAIL out_timeout: got %0d beats, required %0d", got, n);
                    exp_q.delete();
                end
                m_axi4s_tready = 1'b1;
            end
        join
        @(negedge aclk);
        #1 vectors++;
        if (m_axi4s_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL extra_beat: got tvalid=%b, required 0", m_axi4s_tvalid);
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge aclk);
        #1 vectors++;
        if (m_axi4s_tvalid !== 1'b0 || m_axi4s_tdata !== 10'h0 || m_axi4s_tuser !== 1'b0 || m_axi4s_tlast !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b d=%h u=%b l=%b, required all 0",
                     m_axi4s_tvalid, m_axi4s_tdata, m_axi4s_tuser, m_axi4s_tlast);
        end
        @(negedge aclk) aresetn = 1'b1;
    endtask

    task automatic test_wishbone();
        logic [31:0] d;
        wb_read(8'h00, d); vectors++;
        if (d !== 32'h527A_2130) begin miscompares++; $display("FAIL core_id: got %h, required 527a2130", d); end
        wb_read(8'h02, d); vectors++;
        if (d !== 32'h3) begin miscompares++; $display("FAIL param_reset: got %h, required 3", d); end
        wb_read(8'h03, d); vectors++;
        if (d !== 32'h3) begin miscompares++; $display("FAIL current_reset: got %h, required 3", d); end
        wb_read(8'h01, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL pending_reset: got %h, required 0", d); end
        wb_read(8'h04, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL count_reset: got %h, required 0", d); end
        wb_read(8'h07, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped: got %h, required 0", d); end
        wb_write(8'h02, 32'h0, 4'b1110);
        wb_read(8'h02, d); vectors++;
        if (d !== 32'h3) begin miscompares++; $display("FAIL sel_masked: got %h, required 3", d); end
        wb_write(8'h02, 32'h2, 4'b0001);
        wb_read(8'h02, d); vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL param_write: got %h, required 2", d); end
        wb_write(8'h02, 32'h3, 4'b0001);
        wb_read(8'h03, d); vectors++;
        if (d !== 32'h3) begin miscompares++; $display("FAIL current_unchanged: got %h, required 3", d); end
    endtask

    task automatic test_default_phase();
        logic [9:0] tbl [8];
        tbl = '{10'h0AA, 10'h155, 10'h0AA, 10'h155, 10'h155, 10'h3FF, 10'h155, 10'h3FF};
        push_frame(4, 2, 1'b1, 1'b0, 10'h3FF, 10'h155, 10'h0AA);
        run_stream(100, 100);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (i >= recv_q.size() || recv_q[i] !== tbl[i]) begin
                miscompares++;
                $display("FAIL phase11_px%0d: got %h, required %h", i, (i < recv_q.size()) ? recv_q[i] : 10'hx, tbl[i]);
            end
        end
    endtask

    task automatic test_phase00();
        logic [9:0] tbl [8];
        tbl = '{10'h3FF, 10'h155, 10'h3FF, 10'h155, 10'h155, 10'h0AA, 10'h155, 10'h0AA};
        wb_write(8'h02, 32'h0, 4'hF); mparam = 2'b00;
        wb_write(8'h01, 32'h1, 4'hF); mpend = 1'b1;
        push_frame(4, 2, 1'b1, 1'b0, 10'h3FF, 10'h155, 10'h0AA);
        run_stream(100, 100);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (i >= recv_q.size() || recv_q[i] !== tbl[i]) begin
                miscompares++;
                $display("FAIL phase00_px%0d: got %h, required %h", i, (i < recv_q.size()) ? recv_q[i] : 10'hx, tbl[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] tbl [8];
        tbl = '{10'h3FF, 10'h155, 10'h3FF, 10'h155, 10'h155, 10'h0AA, 10'h155, 10'h0AA};
        push_frame(4, 2, 1'b1, 1'b0, 10'h3FF, 10'h155, 10'h0AA);
        run_stream(50, 100);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (i >= recv_q.size() || recv_q[i] !== tbl[i]) begin
                miscompares++;
                $display("FAIL stalled_px%0d: got %h, required %h", i, (i < recv_q.size()) ? recv_q[i] : 10'hx, tbl[i]);
            end
        end
        for (int f = 0; f < 4; f++)
            push_frame(int'($urandom_range(6, 1)), int'($urandom_range(3, 1)), 1'b1, 1'b1, '0, '0, '0);
        run_stream(50, 70);
    endtask

    task automatic test_update_midframe();
        logic [31:0] d;
        push_frame(4, 1, 1'b1, 1'b1, '0, '0, '0);
        run_stream(100, 100);
        wb_write(8'h02, 32'h1, 4'hF); mparam = 2'b01;
        wb_write(8'h01, 32'h1, 4'hF); mpend = 1'b1;
        wb_read(8'h03, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL mid_current: got %h, required 0", d); end
        wb_read(8'h01, d); vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL mid_pending: got %h, required 1", d); end
        push_frame(4, 1, 1'b0, 1'b1, '0, '0, '0);
        run_stream(100, 100);
        wb_read(8'h03, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL eof_current: got %h, required 0", d); end
        push_frame(4, 2, 1'b1, 1'b1, '0, '0, '0);
        run_stream(70, 100);
        wb_read(8'h03, d); vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL new_current: got %h, required 1", d); end
        wb_read(8'h01, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL new_pending: got %h, required 0", d); end
    endtask

    task automatic test_truncated();
        wb_write(8'h02, 32'h0, 4'hF); mparam = 2'b00;
        wb_write(8'h01, 32'h1, 4'hF); mpend = 1'b1;
        for (int i = 0; i < 3; i++) push_beat(i == 0, 1'b0, 10'($urandom), 10'($urandom), 10'($urandom));
        push_frame(4, 2, 1'b1, 1'b0, 10'h3FF, 10'h155, 10'h0AA);
        run_stream(100, 100);
        vectors++;
        if (recv_q.size() < 4 || recv_q[3] !== 10'h3FF) begin
            miscompares++;
            $display("FAIL resync_first: got %h, required 3ff", (recv_q.size() > 3) ? recv_q[3] : 10'hx);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d; out_t e;
        wb_write(8'h01, 32'h1, 4'hF); mpend = 1'b1;
        push_beat(1'b1, 1'b0, 10'h3FF, 10'h155, 10'h0AA);
        in_q.delete();
        e = exp_q.pop_front();
        mparam = 2'b11; mpend = 1'b1;
        @(negedge aclk);
        m_axi4s_tready = 1'b1;
        s_axi4s_tvalid = 1'b1; s_axi4s_tuser = 1'b1; s_axi4s_tlast = 1'b0;
        s_axi4s_tdata = {10'h0, 10'h3FF, 10'h155, 10'h0AA};
        s_wb_adr_i = 8'h02; s_wb_dat_i = 32'h3; s_wb_sel_i = 4'h1; s_wb_we_i = 1'b1; s_wb_stb_i = 1'b1;
        in_update_req = 1'b1;
        @(posedge aclk);
        #1;
        s_axi4s_tvalid = 1'b0; s_axi4s_tuser = '0; s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0; in_update_req = 1'b0;
        vectors++;
        if (m_axi4s_tvalid !== 1'b1 || m_axi4s_tdata !== e.data) begin
            miscompares++;
            $display("FAIL race_pixel: got v=%b d=%h, required v=1 d=%h", m_axi4s_tvalid, m_axi4s_tdata, e.data);
        end
        wb_read(8'h01, d); vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL race_pending: got %h, required 1", d); end
        wb_read(8'h02, d); vectors++;
        if (d !== 32'h3) begin miscompares++; $display("FAIL race_param: got %h, required 3", d); end
        wb_read(8'h03, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL race_current: got %h, required 0", d); end
    endtask

    task automatic test_frame_count();
        logic [31:0] d, req;
`ifdef VIDEO_RGB_TO_RAW_FRAME_COUNT_EN
        req = 32'(mframes);
`else
        req = 32'h0;
`endif
        wb_read(8'h04, d); vectors++;
        if (d !== req) begin miscompares++; $display("FAIL frame_count: got %h, required %h", d, req); end
    endtask

    task automatic test_reset_midline();
        logic [31:0] d;
        m_axi4s_tready = 1'b0;
        @(negedge aclk);
        s_axi4s_tvalid = 1'b1; s_axi4s_tuser = 1'b1; s_axi4s_tdata = {10'h0, 10'h3FF, 10'h155, 10'h0AA};
        @(negedge aclk);
        s_axi4s_tuser = 1'b0;
        #2 aresetn = 1'b0;
        #1 vectors++;
        if (m_axi4s_tvalid !== 1'b0 || m_axi4s_tdata !== 10'h0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b d=%h, required v=0 d=0", m_axi4s_tvalid, m_axi4s_tdata);
        end
        s_axi4s_tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1; m_axi4s_tready = 1'b1;
        model_reset();
        wb_read(8'h02, d); vectors++;
        if (d !== 32'h3) begin miscompares++; $display("FAIL reinit_param: got %h, required 3", d); end
        wb_write(8'h02, 32'h0, 4'hF); mparam = 2'b00;
        wb_write(8'h01, 32'h1, 4'hF); mpend = 1'b1;
        push_frame(4, 2, 1'b1, 1'b0, 10'h3FF, 10'h155, 10'h0AA);
        run_stream(100, 100);
        vectors++;
        if (recv_q.size() < 1 || recv_q[0] !== 10'h3FF) begin
            miscompares++;
            $display("FAIL post_reset_first: got %h, required 3ff", (recv_q.size() > 0) ? recv_q[0] : 10'hx);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wishbone();
        test_default_phase();
        test_phase00();
        test_backpressure();
        test_update_midframe();
        test_truncated();
        test_same_cycle();
        test_frame_count();
        test_reset_midline();
        test_frame_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
